// File: rtl/snake_body_streamer_if.sv
// Serial body-segment stream from the snake store to the graphic renderer.
interface snake_body_streamer_if;
  logic       en_snake_body;
  logic [6:0] snake_body_x;
  logic [6:0] snake_body_y;
  logic       stream_done;

  modport master (output en_snake_body, output snake_body_x, output snake_body_y, output stream_done);
  modport slave  (input  en_snake_body, input  snake_body_x, input  snake_body_y, input  stream_done);
endinterface

// File: rtl/snake_body_streamer.sv
// Snake body segment store: shifts on head moves, streams segments to the
// renderer and flags head-versus-body self-collision during the stream.
module snake_body_streamer #(
  parameter int SNAKE_LENGTH_BIT = 4,
  parameter int SNAKE_LENGTH_MAX = 16,
  parameter int INIT_LENGTH      = 3,
  parameter int INIT_X           = 20,
  parameter int INIT_Y           = 20
) (
  input  logic                        clock_25,
  input  logic                        reset,
  input  logic [6:0]                  snake_head_x,
  input  logic [6:0]                  snake_head_y,
  input  logic                        move_tick,
  input  logic                        grow,
  input  logic                        frame_start,
  input  logic                        blank,
  snake_body_streamer_if.master       body_if,
  output logic [SNAKE_LENGTH_BIT-1:0] snake_length,
  output logic                        self_collision
);

  localparam int unsigned DEPTH = SNAKE_LENGTH_MAX - 1;
  localparam logic [SNAKE_LENGTH_BIT-1:0] LEN_MAX  = SNAKE_LENGTH_BIT'(SNAKE_LENGTH_MAX - 1);
  localparam logic [SNAKE_LENGTH_BIT-1:0] LEN_INIT = SNAKE_LENGTH_BIT'(INIT_LENGTH);

  localparam logic [2:0] IDLE       = 3'd0;
  localparam logic [2:0] SHIFT      = 3'd1;
  localparam logic [2:0] WAIT_BLANK = 3'd2;
  localparam logic [2:0] STREAM     = 3'd3;
  localparam logic [2:0] DONE       = 3'd4;

  logic [2:0]                  state_q, state_d;
  logic [6:0]                  body_x_q [DEPTH];
  logic [6:0]                  body_x_d [DEPTH];
  logic [6:0]                  body_y_q [DEPTH];
  logic [6:0]                  body_y_d [DEPTH];
  logic [6:0]                  prev_x_q, prev_x_d;
  logic [6:0]                  prev_y_q, prev_y_d;
  logic [SNAKE_LENGTH_BIT-1:0] len_q, len_d;
  logic [SNAKE_LENGTH_BIT-1:0] idx_q, idx_d;
  logic                        pend_move_q, pend_move_d;
  logic                        pend_grow_q, pend_grow_d;
  logic                        pend_refresh_q, pend_refresh_d;
  logic                        hit_q, hit_d;
  logic                        coll_q, coll_d;
  logic                        en_q, en_d;
  logic                        done_q, done_d;
  logic [6:0]                  out_x_q, out_x_d;
  logic [6:0]                  out_y_q, out_y_d;

  always_comb begin
    state_d        = state_q;
    body_x_d       = body_x_q;
    body_y_d       = body_y_q;
    prev_x_d       = prev_x_q;
    prev_y_d       = prev_y_q;
    len_d          = len_q;
    idx_d          = idx_q;
    pend_move_d    = pend_move_q | move_tick;
    pend_grow_d    = pend_grow_q | grow;
    pend_refresh_d = pend_refresh_q | frame_start;
    hit_d          = hit_q;
    coll_d         = coll_q;
    en_d           = 1'b0;
    done_d         = 1'b0;
    out_x_d        = out_x_q;
    out_y_d        = out_y_q;

    case (state_q)
      IDLE: begin
        // The live move_tick is looked at too, so SHIFT follows the pulse directly.
        if (pend_move_q || move_tick) begin
          state_d = SHIFT;
        end else if (pend_refresh_q) begin
          state_d = WAIT_BLANK;
        end
      end
      SHIFT: begin
        body_x_d[0] = prev_x_q;
        body_y_d[0] = prev_y_q;
        for (int unsigned i = 1; i < DEPTH; i++) begin
          body_x_d[i] = body_x_q[i-1];
          body_y_d[i] = body_y_q[i-1];
        end
        prev_x_d = snake_head_x;
        prev_y_d = snake_head_y;
        if (pend_grow_q && (len_q < LEN_MAX)) begin
          len_d = len_q + 1'b1;
        end
        // Requests arriving this very cycle must survive the clear.
        pend_move_d    = move_tick;
        pend_grow_d    = grow;
        pend_refresh_d = 1'b1;
        idx_d          = '0;
        // Skipping WAIT_BLANK when blank is already high saves a cycle of latency.
        state_d        = blank ? STREAM : WAIT_BLANK;
      end
      WAIT_BLANK: begin
        if (blank) begin
          idx_d   = '0;
          state_d = STREAM;
        end
      end
      STREAM: begin
        en_d    = 1'b1;
        out_x_d = body_x_q[idx_q];
        out_y_d = body_y_q[idx_q];
        if ((body_x_q[idx_q] == prev_x_q) && (body_y_q[idx_q] == prev_y_q)) begin
          hit_d = 1'b1;
        end
        idx_d = idx_q + 1'b1;
        if (idx_q == len_q - 1'b1) begin
          state_d = DONE;
        end
      end
      DONE: begin
        done_d         = 1'b1;
        coll_d         = coll_q | hit_q;
        hit_d          = 1'b0;
        pend_refresh_d = frame_start;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock_25) begin
    if (!reset) begin
      state_q <= IDLE;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        body_x_q[i] <= 7'(INIT_X - 1 - int'(i));
        body_y_q[i] <= 7'(INIT_Y);
      end
      prev_x_q       <= 7'(INIT_X);
      prev_y_q       <= 7'(INIT_Y);
      len_q          <= LEN_INIT;
      idx_q          <= '0;
      pend_move_q    <= 1'b0;
      pend_grow_q    <= 1'b0;
      pend_refresh_q <= 1'b0;
      hit_q          <= 1'b0;
      coll_q         <= 1'b0;
      en_q           <= 1'b0;
      done_q         <= 1'b0;
      out_x_q        <= '0;
      out_y_q        <= '0;
    end else begin
      state_q        <= state_d;
      body_x_q       <= body_x_d;
      body_y_q       <= body_y_d;
      prev_x_q       <= prev_x_d;
      prev_y_q       <= prev_y_d;
      len_q          <= len_d;
      idx_q          <= idx_d;
      pend_move_q    <= pend_move_d;
      pend_grow_q    <= pend_grow_d;
      pend_refresh_q <= pend_refresh_d;
      hit_q          <= hit_d;
      coll_q         <= coll_d;
      en_q           <= en_d;
      done_q         <= done_d;
      out_x_q        <= out_x_d;
      out_y_q        <= out_y_d;
    end
  end

  assign body_if.en_snake_body = en_q;
  assign body_if.snake_body_x  = out_x_q;
  assign body_if.snake_body_y  = out_y_q;
  assign body_if.stream_done   = done_q;
  assign snake_length          = len_q;
  assign self_collision        = coll_q;

endmodule

// File: tb/tb_snake_body_streamer.sv
// Directed self-checking bench for snake_body_streamer.
module tb_snake_body_streamer;

  logic       clk;
  logic       reset;
  logic [6:0] head_x, head_y;
  logic       move_tick, grow, frame_start, blank;
  logic [3:0] snake_length;
  logic       self_collision;

  snake_body_streamer_if bif ();

  snake_body_streamer #(
    .SNAKE_LENGTH_BIT (4),
    .SNAKE_LENGTH_MAX (16),
    .INIT_LENGTH      (3),
    .INIT_X           (20),
    .INIT_Y           (20)
  ) dut (
    .clock_25       (clk),
    .reset          (reset),
    .snake_head_x   (head_x),
    .snake_head_y   (head_y),
    .move_tick      (move_tick),
    .grow           (grow),
    .frame_start    (frame_start),
    .blank          (blank),
    .body_if        (bif),
    .snake_length   (snake_length),
    .self_collision (self_collision)
  );

  initial clk = 1'b0;
  always #20 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [6:0] cap_x [0:19];
  logic [6:0] cap_y [0:19];
  int         cap_n;
  int         cap_lat;
  logic       cap_timeout;
  logic       cap_done;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0; move_tick = 1'b0; grow = 1'b0; frame_start = 1'b0; blank = 1'b1;
    head_x = 7'd20; head_y = 7'd20;
    tick(); tick();
    reset = 1'b1;
  endtask

  task automatic pulse_move(input logic [6:0] x, input logic [6:0] y, input logic g);
    head_x = x; head_y = y; move_tick = 1'b1; grow = g;
    tick();
    move_tick = 1'b0; grow = 1'b0;
  endtask

  // Waits up to budget cycles for enable, then records segments until it drops.
  task automatic capture_stream(input int budget);
    int c;
    c = 0; cap_n = 0; cap_timeout = 1'b0; cap_done = 1'b0;
    while (!bif.en_snake_body && c < budget) begin
      tick(); c++;
    end
    cap_lat = c;
    if (!bif.en_snake_body) begin
      cap_timeout = 1'b1;
      return;
    end
    while (bif.en_snake_body && cap_n < 20) begin
      cap_x[cap_n] = bif.snake_body_x;
      cap_y[cap_n] = bif.snake_body_y;
      cap_n++;
      tick();
    end
    cap_done = bif.stream_done;
  endtask

  task automatic test_reset();
    logic [6:0] ex [0:2];
    ex[0] = 7'd19; ex[1] = 7'd18; ex[2] = 7'd17;
    reset = 1'b0; move_tick = 1'b0; grow = 1'b0; frame_start = 1'b0; blank = 1'b1;
    head_x = 7'd20; head_y = 7'd20;
    tick(); tick();
    checks++;
    if (bif.en_snake_body !== 1'b0 || bif.stream_done !== 1'b0 || self_collision !== 1'b0) begin
      errors++; $display("FAIL reset_flags got en=%b done=%b coll=%b exp 0 0 0",
                         bif.en_snake_body, bif.stream_done, self_collision);
    end
    checks++;
    if (bif.snake_body_x !== 7'd0 || bif.snake_body_y !== 7'd0) begin
      errors++; $display("FAIL reset_xy got %0d,%0d exp 0,0", bif.snake_body_x, bif.snake_body_y);
    end
    checks++;
    if (snake_length !== 4'd3) begin
      errors++; $display("FAIL reset_len got %0d exp 3", snake_length);
    end
    reset = 1'b1;
    tick();
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    capture_stream(20);
    checks++;
    if (cap_timeout || cap_n != 3) begin
      errors++; $display("FAIL refresh_count got %0d timeout=%b exp 3", cap_n, cap_timeout);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (cap_x[i] !== ex[i] || cap_y[i] !== 7'd20) begin
        errors++; $display("FAIL refresh_seg%0d got %0d,%0d exp %0d,20", i, cap_x[i], cap_y[i], ex[i]);
      end
    end
    checks++;
    if (cap_done !== 1'b1) begin
      errors++; $display("FAIL refresh_done got %b exp 1", cap_done);
    end
    tick();
    checks++;
    if (bif.stream_done !== 1'b0) begin
      errors++; $display("FAIL done_pulse_width got %b exp 0", bif.stream_done);
    end
  endtask

  task automatic test_move();
    logic [6:0] ex [0:2];
    ex[0] = 7'd20; ex[1] = 7'd19; ex[2] = 7'd18;
    do_reset();
    tick();
    pulse_move(7'd21, 7'd20, 1'b0);
    capture_stream(20);
    checks++;
    if (cap_lat != 2) begin
      errors++; $display("FAIL move_latency got %0d exp 2", cap_lat);
    end
    checks++;
    if (cap_timeout || cap_n != 3) begin
      errors++; $display("FAIL move_count got %0d timeout=%b exp 3", cap_n, cap_timeout);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (cap_x[i] !== ex[i] || cap_y[i] !== 7'd20) begin
        errors++; $display("FAIL move_seg%0d got %0d,%0d exp %0d,20", i, cap_x[i], cap_y[i], ex[i]);
      end
    end
    checks++;
    if (snake_length !== 4'd3) begin
      errors++; $display("FAIL move_len got %0d exp 3", snake_length);
    end
    checks++;
    if (bif.snake_body_x !== 7'd18) begin
      errors++; $display("FAIL hold_x got %0d exp 18", bif.snake_body_x);
    end
  endtask

  task automatic test_grow();
    logic [6:0] ex [0:3];
    ex[0] = 7'd21; ex[1] = 7'd20; ex[2] = 7'd19; ex[3] = 7'd18;
    pulse_move(7'd22, 7'd20, 1'b1);
    capture_stream(20);
    checks++;
    if (cap_timeout || cap_n != 4) begin
      errors++; $display("FAIL grow_count got %0d timeout=%b exp 4", cap_n, cap_timeout);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (cap_x[i] !== ex[i] || cap_y[i] !== 7'd20) begin
        errors++; $display("FAIL grow_seg%0d got %0d,%0d exp %0d,20", i, cap_x[i], cap_y[i], ex[i]);
      end
    end
    checks++;
    if (snake_length !== 4'd4) begin
      errors++; $display("FAIL grow_len got %0d exp 4", snake_length);
    end
  endtask

  task automatic test_blank_wait();
    logic seen;
    do_reset();
    blank = 1'b0;
    tick();
    pulse_move(7'd21, 7'd20, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (bif.en_snake_body) seen = 1'b1;
      tick();
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++; $display("FAIL blank_hold got en=%b exp 0", seen);
    end
    blank = 1'b1;
    capture_stream(20);
    checks++;
    if (cap_timeout || cap_n != 3 || cap_x[0] !== 7'd20 || cap_x[2] !== 7'd18) begin
      errors++; $display("FAIL blank_stream got n=%0d x0=%0d x2=%0d exp n=3 x0=20 x2=18",
                         cap_n, cap_x[0], cap_x[2]);
    end
    capture_stream(30);
    checks++;
    if (!cap_timeout) begin
      errors++; $display("FAIL blank_single got extra stream n=%0d exp none", cap_n);
    end
  endtask

  task automatic test_saturate();
    do_reset();
    tick();
    for (int k = 0; k < 13; k++) begin
      pulse_move(7'(21 + k), 7'd20, 1'b1);
      capture_stream(20);
    end
    checks++;
    if (snake_length !== 4'd15) begin
      errors++; $display("FAIL sat_len13 got %0d exp 15", snake_length);
    end
    pulse_move(7'd34, 7'd20, 1'b1);
    capture_stream(20);
    checks++;
    if (snake_length !== 4'd15) begin
      errors++; $display("FAIL sat_len14 got %0d exp 15", snake_length);
    end
    checks++;
    if (cap_timeout || cap_n != 15) begin
      errors++; $display("FAIL sat_count got %0d timeout=%b exp 15", cap_n, cap_timeout);
    end
    checks++;
    if (cap_x[0] !== 7'd33 || cap_x[14] !== 7'd19) begin
      errors++; $display("FAIL sat_ends got %0d,%0d exp 33,19", cap_x[0], cap_x[14]);
    end
  endtask

  task automatic test_collision();
    do_reset();
    tick();
    pulse_move(7'd21, 7'd20, 1'b1); capture_stream(20);
    pulse_move(7'd21, 7'd21, 1'b0); capture_stream(20);
    pulse_move(7'd20, 7'd21, 1'b0); capture_stream(20);
    checks++;
    if (self_collision !== 1'b0 || snake_length !== 4'd4) begin
      errors++; $display("FAIL coll_before got coll=%b len=%0d exp 0 4", self_collision, snake_length);
    end
    pulse_move(7'd20, 7'd20, 1'b0); capture_stream(20);
    checks++;
    if (self_collision !== 1'b1) begin
      errors++; $display("FAIL coll_set got %b exp 1", self_collision);
    end
    checks++;
    if (cap_n != 4 || cap_x[3] !== 7'd20 || cap_y[3] !== 7'd20) begin
      errors++; $display("FAIL coll_tail got n=%0d %0d,%0d exp 4 20,20", cap_n, cap_x[3], cap_y[3]);
    end
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    capture_stream(20);
    checks++;
    if (self_collision !== 1'b1 || cap_n != 4) begin
      errors++; $display("FAIL coll_sticky got coll=%b n=%0d exp 1 4", self_collision, cap_n);
    end
    do_reset();
    checks++;
    if (self_collision !== 1'b0) begin
      errors++; $display("FAIL coll_reset got %b exp 0", self_collision);
    end
  endtask

  initial begin
    test_reset();
    test_move();
    test_grow();
    test_blank_wait();
    test_saturate();
    test_collision();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
